// File: rtl/ethernet_mmio_pkg.sv
// Shared Ethernet MMIO register map, access-size encoding and echo-engine states.
package ethernet_mmio_pkg;

  localparam logic [15:0] RX_BUF_ADDR   = 16'h0000;
  localparam logic [15:0] TX_BUF_ADDR   = 16'h0800;
  localparam logic [15:0] RX_LEN_ADDR   = 16'h1004;
  localparam logic [15:0] RX_PEND_ADDR  = 16'h1010;
  localparam logic [15:0] TX_SEND_ADDR  = 16'h1018;
  localparam logic [15:0] TX_READY_ADDR = 16'h101C;
  localparam logic [15:0] TX_LEN_ADDR   = 16'h1028;

  typedef enum logic [1:0] {
    OP_BYTE = 2'd0,
    OP_HALF = 2'd1,
    OP_WORD = 2'd2
  } op_size_e;

  typedef enum logic [3:0] {
    S_IDLE, S_POLL_RX, S_RX_PEND_W, S_RD_LEN, S_LEN_W, S_POLL_TX, S_TX_W,
    S_TX_GAP, S_COPY_RD, S_COPY_WR, S_WR_LEN, S_SEND, S_CLR_RX, S_POLL_GAP,
    S_ERROR
  } state_e;

endpackage

// File: rtl/bsg_dff_reset.sv
// Plain D flip-flop bank with synchronous active-high reset to a constant.
module bsg_dff_reset #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) data_o <= reset_val_p;
    else         data_o <= data_i;
  end

endmodule

// File: rtl/ethernet_mmio_poll_timer.sv
// Down-counter spacing status polls; start loads the gap, done is high once it has elapsed.
module ethernet_mmio_poll_timer #(
  parameter int poll_gap_p = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic done_o
);

  localparam int cnt_w_lp = $clog2(poll_gap_p + 1);

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  // Loading gap-1 makes done land on the last of poll_gap_p waiting cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i)             cnt_d = cnt_w_lp'(poll_gap_p - 1);
    else if (cnt_q != '0)    cnt_d = cnt_q - cnt_w_lp'(1);
  end

  bsg_dff_reset #(.width_p(cnt_w_lp)) cnt_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(cnt_d), .data_o(cnt_q)
  );

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ethernet_mmio_echo_initiator.sv
// Hardware MMIO initiator that echoes each received Ethernet frame back out through the TX buffer.
module ethernet_mmio_echo_initiator
  import ethernet_mmio_pkg::*;
#(
  parameter int buf_size_p   = 2048,
  parameter int axis_width_p = 32,
  parameter int poll_gap_p   = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  output logic [15:0]             addr_o,
  output logic                    read_en_o,
  output logic                    write_en_o,
  output logic [1:0]              op_size_o,
  output logic [axis_width_p-1:0] write_data_o,
  input  logic [axis_width_p-1:0] read_data_i,
  input  logic                    read_data_v_i,
  input  logic                    io_decode_error_i,
  output logic                    busy_o,
  output logic                    error_o,
  output logic [15:0]             echo_count_o,
  output logic [15:0]             drop_count_o
);

  localparam int          bpw_lp      = axis_width_p / 8;
  localparam int          off_w_lp    = $clog2(buf_size_p) + 1;
  localparam logic [16:0] buf_size_lp = 17'(buf_size_p);

  state_e                state_q, state_d;
  logic [3:0]            state_raw;
  logic [15:0]           len_q, len_d;
  logic [off_w_lp-1:0]   off_q, off_d, off_inc;
  logic [15:0]           echo_q, echo_d, drop_q, drop_d;
  logic                  gap_start, gap_done;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    off_d        = off_q;
    echo_d       = echo_q;
    drop_d       = drop_q;
    gap_start    = 1'b0;
    addr_o       = '0;
    read_en_o    = 1'b0;
    write_en_o   = 1'b0;
    write_data_o = '0;
    off_inc      = off_q + off_w_lp'(bpw_lp);

    unique case (state_q)
      S_IDLE:      if (enable_i) state_d = S_POLL_RX;
      S_POLL_RX: begin
        read_en_o = 1'b1;
        addr_o    = RX_PEND_ADDR;
        state_d   = S_RX_PEND_W;
      end
      S_RX_PEND_W: begin
        if (read_data_i[0]) state_d = S_RD_LEN;
        else begin
          gap_start = 1'b1;
          state_d   = S_POLL_GAP;
        end
      end
      S_RD_LEN: begin
        read_en_o = 1'b1;
        addr_o    = RX_LEN_ADDR;
        state_d   = S_LEN_W;
      end
      S_LEN_W: begin
        len_d = read_data_i[15:0];
        off_d = '0;
        if (read_data_i[15:0] == 16'd0) state_d = S_CLR_RX;
        else if ({1'b0, read_data_i[15:0]} > buf_size_lp) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = S_CLR_RX;
        end else state_d = S_POLL_TX;
      end
      S_POLL_TX: begin
        read_en_o = 1'b1;
        addr_o    = TX_READY_ADDR;
        state_d   = S_TX_W;
      end
      S_TX_W: begin
        if (read_data_i[0]) state_d = S_COPY_RD;
        else begin
          gap_start = 1'b1;
          state_d   = S_TX_GAP;
        end
      end
      S_TX_GAP:    if (gap_done) state_d = S_POLL_TX;
      S_COPY_RD: begin
        read_en_o = 1'b1;
        addr_o    = RX_BUF_ADDR + 16'(off_q);
        state_d   = S_COPY_WR;
      end
      S_COPY_WR: begin
        // Data goes straight from the read bus to the write bus; no staging register.
        write_en_o   = read_data_v_i;
        addr_o       = TX_BUF_ADDR + 16'(off_q);
        write_data_o = read_data_i;
        off_d        = off_inc;
        state_d      = (16'(off_inc) >= len_q) ? S_WR_LEN : S_COPY_RD;
      end
      S_WR_LEN: begin
        write_en_o   = 1'b1;
        addr_o       = TX_LEN_ADDR;
        write_data_o = axis_width_p'(len_q);
        state_d      = S_SEND;
      end
      S_SEND: begin
        write_en_o   = 1'b1;
        addr_o       = TX_SEND_ADDR;
        write_data_o = axis_width_p'(1);
        echo_d       = echo_q + 16'd1;
        state_d      = S_CLR_RX;
      end
      S_CLR_RX: begin
        write_en_o   = 1'b1;
        addr_o       = RX_PEND_ADDR;
        write_data_o = axis_width_p'(1);
        gap_start    = 1'b1;
        state_d      = S_POLL_GAP;
      end
      S_POLL_GAP:  if (gap_done) state_d = enable_i ? S_POLL_RX : S_IDLE;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase

    // Protocol faults override the normal transition and freeze the counters.
    if (((read_en_o | write_en_o) && io_decode_error_i) ||
        ((state_q inside {S_RX_PEND_W, S_LEN_W, S_TX_W, S_COPY_WR}) && !read_data_v_i)) begin
      state_d = S_ERROR;
      echo_d  = echo_q;
      drop_d  = drop_q;
    end
  end

  bsg_dff_reset #(.width_p(4)) state_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(state_d), .data_o(state_raw)
  );
  assign state_q = state_e'(state_raw);

  bsg_dff_reset #(.width_p(16)) len_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(len_d), .data_o(len_q)
  );
  bsg_dff_reset #(.width_p(off_w_lp)) off_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(off_d), .data_o(off_q)
  );
  bsg_dff_reset #(.width_p(16)) echo_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(echo_d), .data_o(echo_q)
  );
  bsg_dff_reset #(.width_p(16)) drop_reg (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(drop_d), .data_o(drop_q)
  );

  ethernet_mmio_poll_timer #(.poll_gap_p(poll_gap_p)) poll_timer (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(gap_start), .done_o(gap_done)
  );

  assign op_size_o    = (read_en_o | write_en_o) ? OP_WORD : OP_BYTE;
  assign busy_o       = !(state_q inside {S_IDLE, S_POLL_GAP});
  assign error_o      = (state_q == S_ERROR);
  assign echo_count_o = echo_q;
  assign drop_count_o = drop_q;

endmodule
